// File: rtl/imem_loader_pkg.sv
// Instruction-memory geometry and loader state encoding, shared with the
// instruction memory so that depth and word width stay aligned.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH     = 1024;
  localparam int unsigned IMEM_ADDR_W    = 10;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid_o pulses
// combinationally together with the handshake of the fourth byte.
module byte_packer
  import imem_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  clear_i,
  input  logic  byte_valid_i,
  input  byte_t byte_i,
  output logic  word_valid_o,
  output word_t word_o
);

  logic [1:0] idx_q, idx_d;
  word_t      pack_q, pack_d;
  word_t      merged;

  always_comb begin
    merged                       = pack_q;
    merged[{idx_q, 3'b000} +: 8] = byte_i;
  end

  always_comb begin
    idx_d        = idx_q;
    pack_d       = pack_q;
    word_valid_o = 1'b0;
    word_o       = merged;
    if (clear_i) begin
      idx_d  = '0;
      pack_d = '0;
    end else if (byte_valid_i) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        word_valid_o = 1'b1;
        pack_d       = '0;
      end else begin
        pack_d = merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      pack_q <= '0;
    end else begin
      idx_q  <= idx_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory at word addresses 0..len-1 while
// holding the CPU. Optional checksum trailer: define IMEM_LOADER_CSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH  = IMEM_DEPTH,
  parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done
`ifdef IMEM_LOADER_CSUM_EN
  ,
  output logic [31:0]       csum,
  output logic              csum_err
`endif
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  word_t             wdata_q, wdata_d;

  logic  start_ok;
  logic  accept;
  logic  all_written;
  logic  word_valid;
  word_t word;

`ifdef IMEM_LOADER_CSUM_EN
  word_t csum_q, csum_d;
  logic  err_q, err_d;
`endif

  assign start_ok    = start && ((state_q == IDLE) || (state_q == DONE));
  assign all_written = (cnt_q == len_q);
  assign accept      = in_valid && in_ready;

  byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (start_ok),
    .byte_valid_i (accept),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d   = (load_len > DEPTH_L) ? DEPTH_L : load_len;
          cnt_d   = '0;
          state_d = (len_d == '0) ? DONE : LOAD;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (word_valid && !all_written) begin
          we_d    = 1'b1;
          waddr_d = cnt_q[ADDR_W-1:0];
          wdata_d = word;
          cnt_d   = cnt_q + 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d  = csum_q ^ word;
`endif
        end
`ifdef IMEM_LOADER_CSUM_EN
        // Once every data word is written, the next complete word is the trailer.
        if (word_valid && all_written) begin
          err_d   = (word != csum_q);
          state_d = FLUSH;
        end
`else
        if (all_written) state_d = FLUSH;
`endif
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

`ifdef IMEM_LOADER_CSUM_EN
  assign in_ready = (state_q == LOAD);
  assign csum     = csum_q;
  assign csum_err = (state_q == DONE) && err_q;
`else
  // Ready drops during the final write cycle, so no byte beyond len*4 is taken.
  assign in_ready = (state_q == LOAD) && !all_written;
`endif

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = (state_q != DONE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven randomized loads against
// a byte-stream reference model, plus hand-written corner-case sequences.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;
`ifdef IMEM_LOADER_CSUM_EN
  localparam int CSUM_BYTES = 4;
  localparam int DONE_LAT   = 2;
`else
  localparam int CSUM_BYTES = 0;
  localparam int DONE_LAT   = 3;
`endif

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   load_len;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
`ifdef IMEM_LOADER_CSUM_EN
  logic [31:0]       csum;
  logic              csum_err;
`endif

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_len   (load_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
`ifdef IMEM_LOADER_CSUM_EN
    .csum       (csum),
    .csum_err   (csum_err),
`endif
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  stim[$];
  logic [31:0] exp_words[$];
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          hs4_cyc[$];
  int          n_hs, last_hs_cyc, done_cyc, start_cyc;
  bit          timed_out;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(int'(imem_waddr));
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); hs4_cyc.delete();
    stim.delete(); exp_words.delete();
  endtask

  // Reference model: word i is bytes 4i..4i+3, little-endian; csum is their XOR.
  function automatic logic [31:0] build_model(input int nw);
    logic [31:0] x = '0;
    for (int i = 0; i < nw; i++) begin
      logic [31:0] w = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
      exp_words.push_back(w);
      x ^= w;
    end
    return x;
  endfunction

  task automatic do_start(input int len);
    load_len = (ADDR_W + 1)'(len);
    start    = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  // mode 0: valid always; 1: valid every other cycle; 2: random valid.
  task automatic feed(input int mode, input int stop_bytes, input int budget);
    n_hs = 0; last_hs_cyc = -1; done_cyc = -1; timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      bit v;
      if (done === 1'b1) begin done_cyc = cyc; timed_out = 1'b0; break; end
      if (n_hs >= stop_bytes) begin timed_out = 1'b0; break; end
      case (mode)
        0:       v = 1'b1;
        1:       v = (c[0] == 1'b0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v && (n_hs < stim.size());
      in_data  = in_valid ? stim[n_hs] : 8'($urandom);
      @(negedge clk);
      if (in_valid && in_ready === 1'b1) begin
        if ((n_hs % 4) == 3) hs4_cyc.push_back(cyc);
        last_hs_cyc = cyc;
        n_hs++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_writes(input int nw);
    chk("write_count", 64'(wr_addr.size()), 64'(nw));
    for (int i = 0; i < nw && i < wr_addr.size(); i++) begin
      chk($sformatf("waddr[%0d]", i), 64'(wr_addr[i]), 64'(i));
      chk($sformatf("wdata[%0d]", i), 64'(wr_data[i]), 64'(exp_words[i]));
      if (i < hs4_cyc.size())
        chk($sformatf("wlat[%0d]", i), 64'(wr_cyc[i]), 64'(hs4_cyc[i] + 1));
    end
  endtask

  typedef struct { int len; int mode; int exp_w; } vec_t;
  vec_t tbl[8];

  task automatic run_case(input int k);
    logic [31:0] x;
    int nw = tbl[k].exp_w;
    clear_logs();
    for (int i = 0; i < 4 * nw; i++) stim.push_back(8'($urandom));
    x = build_model(nw);
    if (nw > 0) for (int b = 0; b < CSUM_BYTES; b++) stim.push_back(x[8*b +: 8]);
    for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
    do_start(tbl[k].len);
    if (nw > 0) chk($sformatf("v%0d_restart_hold", k), {done, cpu_hold}, 2'b01);
    feed(tbl[k].mode, 1 << 30, 20 * (4 * nw + 8) + 20);
    chk($sformatf("v%0d_timeout", k), 64'(timed_out), 0);
    check_writes(nw);
    chk($sformatf("v%0d_bytes", k), 64'(n_hs), 64'(nw > 0 ? 4 * nw + CSUM_BYTES : 0));
    chk($sformatf("v%0d_done_state", k), {done, cpu_hold, in_ready}, 3'b100);
    if (nw > 0) chk($sformatf("v%0d_done_lat", k), 64'(done_cyc), 64'(last_hs_cyc + DONE_LAT));
    else        chk($sformatf("v%0d_done_lat", k), 64'(done_cyc), 64'(start_cyc));
`ifdef IMEM_LOADER_CSUM_EN
    chk($sformatf("v%0d_csum", k), 64'(csum), 64'(x));
    chk($sformatf("v%0d_csum_err", k), 64'(csum_err), 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("v%0d_no_late_write", k), 64'(wr_addr.size()), 64'(nw));
  endtask

  task automatic run_fixed(input int mode, input bit corrupt);
    clear_logs();
    stim = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    void'(build_model(2));
`ifdef IMEM_LOADER_CSUM_EN
    stim.push_back(8'h80); stim.push_back(8'h00);
    stim.push_back(corrupt ? 8'h31 : 8'h30); stim.push_back(8'h00);
`endif
    do_start(2);
    feed(mode, 1 << 30, 200);
    chk("fix_timeout", 64'(timed_out), 0);
    chk("fix_count", 64'(wr_addr.size()), 2);
    if (wr_addr.size() == 2) begin
      chk("fix_w0", {32'(wr_addr[0]), wr_data[0]}, {32'd0, 32'h00100013});
      chk("fix_w1", {32'(wr_addr[1]), wr_data[1]}, {32'd1, 32'h00200093});
      chk("fix_lat0", 64'(wr_cyc[0]), 64'(hs4_cyc[0] + 1));
      chk("fix_lat1", 64'(wr_cyc[1]), 64'(hs4_cyc[1] + 1));
`ifndef IMEM_LOADER_CSUM_EN
      chk("fix_done_lat", 64'(done_cyc), 64'(wr_cyc[1] + 2));
`endif
    end
    chk("fix_done_state", {done, cpu_hold, in_ready}, 3'b100);
`ifdef IMEM_LOADER_CSUM_EN
    chk("fix_csum", 64'(csum), 64'h00300080);
    chk("fix_csum_err", 64'(csum_err), 64'(corrupt));
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; load_len = '0; in_valid = 1'b0; in_data = '0;
    tbl[0] = '{len: 2,    mode: 0, exp_w: 2};
    tbl[1] = '{len: 2,    mode: 1, exp_w: 2};
    tbl[2] = '{len: 1,    mode: 2, exp_w: 1};
    tbl[3] = '{len: 5,    mode: 2, exp_w: 5};
    tbl[4] = '{len: 3,    mode: 1, exp_w: 3};
    tbl[5] = '{len: 0,    mode: 0, exp_w: 0};
    tbl[6] = '{len: 1100, mode: 0, exp_w: 1024};
    tbl[7] = '{len: 1024, mode: 2, exp_w: 1024};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {in_ready, imem_we, 32'(imem_waddr), imem_wdata, cpu_hold, done},
        {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0});
    reset = 1'b0;
    @(posedge clk); #1;

    run_fixed(0, 1'b0);
    run_fixed(1, 1'b0);
`ifdef IMEM_LOADER_CSUM_EN
    run_fixed(2, 1'b1);
`endif

    for (int k = 0; k < 8; k++) run_case(k);

    // Reset part-way through a 3-word load, then reload from address 0.
    clear_logs();
    for (int i = 0; i < 12; i++) stim.push_back(8'($urandom));
    void'(build_model(1));
    do_start(3);
    feed(0, 6, 100);
    chk("rst_bytes", 64'(n_hs), 6);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_outputs", {in_ready, imem_we, 32'(imem_waddr), imem_wdata, cpu_hold, done},
        {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0});
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_writes(1);
    clear_logs();
    for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
    void'(build_model(1));
`ifdef IMEM_LOADER_CSUM_EN
    stim.insert(4, exp_words[0][31:24]); stim.insert(4, exp_words[0][23:16]);
    stim.insert(4, exp_words[0][15:8]);  stim.insert(4, exp_words[0][7:0]);
`endif
    do_start(1);
    feed(2, 1 << 30, 300);
    chk("rst_reload_timeout", 64'(timed_out), 0);
    check_writes(1);
    chk("rst_reload_done", {done, cpu_hold}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
